// File: rtl/bridge_reg_slave_pkg.sv
// ---------------------------------------------------------------------------
// pocket -- shared types and register map for the bridge register slave.
//
// Contents:
//   bridge_addr_t / bridge_data_t : address and data widths of the bridge bus
//   reg_idx_t                     : 4-bit word index inside the 64-byte window
//   *_BASE / *_IDX                : register index constants
//   reg_kind_t, decode_kind()     : classification of an index into its role
//   window_hit()                  : base-window comparison (64-byte aligned)
// ---------------------------------------------------------------------------
package pocket;

    typedef logic [31:0] bridge_addr_t;
    typedef logic [31:0] bridge_data_t;
    typedef logic [3:0]  reg_idx_t;

    localparam int NUM_CTRL   = 8;
    localparam int NUM_STATUS = 4;

    localparam reg_idx_t CTRL_BASE   = 4'd0;
    localparam reg_idx_t STATUS_BASE = 4'd8;
    localparam reg_idx_t STICKY_IDX  = 4'd12;
    localparam reg_idx_t CMD_IDX     = 4'd13;
    localparam reg_idx_t ID_IDX      = 4'd15;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_STATUS,
        REG_STICKY,
        REG_CMD,
        REG_ZERO,
        REG_ID
    } reg_kind_t;

    // Role of a word index; index 14 is a reserved read-as-zero slot.
    function automatic reg_kind_t decode_kind(input reg_idx_t idx);
        reg_kind_t kind;
        if (idx < STATUS_BASE) begin
            kind = REG_CTRL;
        end else if (idx < STICKY_IDX) begin
            kind = REG_STATUS;
        end else if (idx == STICKY_IDX) begin
            kind = REG_STICKY;
        end else if (idx == CMD_IDX) begin
            kind = REG_CMD;
        end else if (idx == ID_IDX) begin
            kind = REG_ID;
        end else begin
            kind = REG_ZERO;
        end
        return kind;
    endfunction

    // The window is 64 bytes, so only address bits 31:6 take part in the match.
    function automatic logic window_hit(input bridge_addr_t addr, input bridge_addr_t base);
        return (addr[31:6] == base[31:6]);
    endfunction

endpackage

// File: rtl/bridge_if.sv
// ---------------------------------------------------------------------------
// bridge_if -- simple single-cycle register bus, synchronous to the clk of the
// responder that it is connected to.
//
// Signals:
//   addr    : byte address of the access
//   wr_data : write data
//   wr      : write qualifier, one cycle per write
//   rd      : read qualifier, one cycle per read
//   rd_data : read data, valid from the cycle after rd and held until next rd
// Modports:
//   responder : slave end (addr/wr_data/wr/rd in, rd_data out)
//   requester : master end
// ---------------------------------------------------------------------------
interface bridge_if;

    pocket::bridge_addr_t addr;
    pocket::bridge_data_t wr_data;
    logic                 wr;
    logic                 rd;
    pocket::bridge_data_t rd_data;

    modport responder (
        input  addr,
        input  wr_data,
        input  wr,
        input  rd,
        output rd_data
    );

    modport requester (
        output addr,
        output wr_data,
        output wr,
        output rd,
        input  rd_data
    );

endinterface

// File: rtl/bridge_sticky_bits.sv
// ---------------------------------------------------------------------------
// bridge_sticky_bits -- 32 independent sticky flags with write-1-to-clear.
//
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset, clears all flags
//   set     : per-bit set request (event pulses)
//   clr     : per-bit clear request (W1C data, already qualified)
//   value   : current flag state
//
// A set and a clear of the same bit in one cycle leaves the bit set, so an
// event arriving while software acknowledges the previous one is never lost.
// ---------------------------------------------------------------------------
module bridge_sticky_bits
    import pocket::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  bridge_data_t set,
    input  bridge_data_t clr,
    output bridge_data_t value
);

    bridge_data_t value_reg;
    bridge_data_t value_next;

    generate
        for (genvar gi = 0; gi < $bits(bridge_data_t); gi++) begin : g_bit
            assign value_next[gi] = set[gi] | (value_reg[gi] & ~clr[gi]);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    value_reg[gi] <= 1'b0;
                end else begin
                    value_reg[gi] <= value_next[gi];
                end
            end
        end
    endgenerate

    assign value = value_reg;

endmodule

// File: rtl/bridge_reg_slave.sv
// ---------------------------------------------------------------------------
// bridge_reg_slave -- 16-word register window on the bridge bus.
//
// Parameters:
//   BASE_ADDR : 64-byte-aligned base address of the window
//   ID_VALUE  : constant returned by word 15
// Ports:
//   clk       : clock (bridge bus is synchronous to it)
//   reset_n   : asynchronous active-low reset
//   bridge    : bridge_if responder end
//   ctrl      : control registers, words 0-7 (read/write)
//   status    : status inputs, words 8-11 (read-only)
//   event_in  : event pulses feeding the sticky word 12 (W1C)
//   cmd_pulse : one-cycle strobe of the data written to word 13
//
// Word 13 and 14 read as zero; word 15 returns ID_VALUE. Reads are registered:
// the value selected in the rd cycle appears on rd_data in the next cycle and
// is held until the following rd. A missed read returns zero so several
// responders may share the return path through an OR.
// ---------------------------------------------------------------------------
module bridge_reg_slave
    import pocket::*;
#(
    parameter bridge_addr_t BASE_ADDR = 32'h0000_0000,
    parameter bridge_data_t ID_VALUE  = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    bridge_if.responder                   bridge,
    output bridge_data_t [NUM_CTRL-1:0]   ctrl,
    input  bridge_data_t [NUM_STATUS-1:0] status,
    input  bridge_data_t                  event_in,
    output bridge_data_t                  cmd_pulse
);

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    logic      hit;
    reg_idx_t  idx;
    reg_kind_t kind;
    logic      wr_hit;
    logic      unused_addr_bits;

    assign hit    = window_hit(bridge.addr, BASE_ADDR);
    assign idx    = bridge.addr[5:2];
    assign kind   = decode_kind(idx);
    assign wr_hit = bridge.wr & hit;

    // Byte-lane bits are not part of the register decode.
    assign unused_addr_bits = &{1'b0, bridge.addr[1:0]};

    // ---------------------------------------------------------------------
    // Control registers
    // ---------------------------------------------------------------------
    bridge_data_t [NUM_CTRL-1:0] ctrl_reg;
    logic         [NUM_CTRL-1:0] ctrl_we;

    generate
        for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
            assign ctrl_we[gi] = wr_hit && (kind == REG_CTRL) && (idx[2:0] == 3'(gi));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ctrl_reg[gi] <= '0;
                end else if (ctrl_we[gi]) begin
                    ctrl_reg[gi] <= bridge.wr_data;
                end
            end
        end
    endgenerate

    assign ctrl = ctrl_reg;

    // ---------------------------------------------------------------------
    // Sticky event word
    // ---------------------------------------------------------------------
    bridge_data_t sticky_clr;
    bridge_data_t sticky_value;

    assign sticky_clr = (wr_hit && (kind == REG_STICKY)) ? bridge.wr_data : '0;

    bridge_sticky_bits u_sticky (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (event_in),
        .clr     (sticky_clr),
        .value   (sticky_value)
    );

    // ---------------------------------------------------------------------
    // Command strobe: reloaded every cycle, so it is nonzero for exactly the
    // cycle after the write and zero otherwise.
    // ---------------------------------------------------------------------
    bridge_data_t cmd_pulse_reg;
    bridge_data_t cmd_pulse_next;

    assign cmd_pulse_next = (wr_hit && (kind == REG_CMD)) ? bridge.wr_data : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_pulse_reg <= '0;
        end else begin
            cmd_pulse_reg <= cmd_pulse_next;
        end
    end

    assign cmd_pulse = cmd_pulse_reg;

    // ---------------------------------------------------------------------
    // Read path. The mux looks at register outputs, so a write and read of
    // the same word in one cycle returns the value from before the write.
    // ---------------------------------------------------------------------
    bridge_data_t rd_sel;
    bridge_data_t rd_data_reg;
    bridge_data_t rd_data_next;

    always_comb begin
        rd_sel = '0;
        if (hit) begin
            case (kind)
                REG_CTRL:   rd_sel = ctrl_reg[idx[2:0]];
                REG_STATUS: rd_sel = status[idx[1:0]];
                REG_STICKY: rd_sel = sticky_value;
                REG_ID:     rd_sel = ID_VALUE;
                default:    rd_sel = '0;
            endcase
        end
    end

    always_comb begin
        rd_data_next = rd_data_reg;
        if (bridge.rd) begin
            rd_data_next = rd_sel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= rd_data_next;
        end
    end

    assign bridge.rd_data = rd_data_reg;

endmodule

// File: tb/tb_bridge_reg_slave.sv
// ---------------------------------------------------------------------------
// Testbench for bridge_reg_slave. Stimulus is applied one bus cycle at a time
// through step(); a register-map model (arrays and plain arithmetic) predicts
// ctrl, the sticky word, rd_data and cmd_pulse. Each test task compares DUT
// outputs against the model one step after the stimulus edge.
// ---------------------------------------------------------------------------
module tb_bridge_reg_slave;
    import pocket::*;

    localparam bridge_addr_t BASE = 32'h4000_0100;
    localparam bridge_data_t ID   = 32'hC0DE_0015;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bridge_if bus ();

    bridge_data_t [7:0] ctrl;
    bridge_data_t [3:0] status;
    bridge_data_t       event_in;
    bridge_data_t       cmd_pulse;

    bridge_reg_slave #(
        .BASE_ADDR (BASE),
        .ID_VALUE  (ID)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bridge    (bus),
        .ctrl      (ctrl),
        .status    (status),
        .event_in  (event_in),
        .cmd_pulse (cmd_pulse)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the register map
    bridge_data_t m_ctrl [8];
    bridge_data_t m_sticky;
    bridge_data_t m_rd;
    bridge_data_t m_cmd;

    function automatic logic in_window(input bridge_addr_t a);
        return (a >> 6) == (BASE >> 6);
    endfunction

    function automatic bridge_data_t ref_read(input bridge_addr_t a);
        int i;
        if (!in_window(a)) return '0;
        i = int'(a[5:2]);
        if (i < 8)   return m_ctrl[i];
        if (i < 12)  return status[i-8];
        if (i == 12) return m_sticky;
        if (i == 15) return ID;
        return '0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_ctrl[i] = '0;
        m_sticky = '0;
        m_rd     = '0;
        m_cmd    = '0;
    endfunction

    // One bus cycle: drive, predict, clock, then release the qualifiers.
    // Returns 1 ns after the sampling edge, where outputs are compared.
    task automatic step(input logic w, input logic r, input bridge_addr_t a,
                        input bridge_data_t d, input bridge_data_t ev);
        int i;
        bridge_data_t clr;
        bus.wr      = w;
        bus.rd      = r;
        bus.addr    = a;
        bus.wr_data = d;
        event_in    = ev;
        i   = int'(a[5:2]);
        clr = '0;
        if (r) m_rd = ref_read(a);
        m_cmd = (w && in_window(a) && i == 13) ? d : '0;
        if (w && in_window(a) && i < 8) m_ctrl[i] = d;
        if (w && in_window(a) && i == 12) clr = d;
        m_sticky = (m_sticky & ~clr) | ev;
        @(posedge clk);
        #1;
        bus.wr   = 1'b0;
        bus.rd   = 1'b0;
        event_in = '0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, BASE, '0, '0);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = BASE; bus.wr_data = '0;
        event_in = '0;
        status = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Accesses and events during reset must be ignored.
        bus.wr = 1'b1; bus.wr_data = 32'hFFFF_FFFF; bus.addr = BASE + 32'h34;
        event_in = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.addr = BASE;
        @(posedge clk); #1;
        bus.wr = 1'b0; event_in = '0;
        checks++;
        if (ctrl !== '0) begin
            errors++; $display("FAIL reset_ctrl got %h expected 0", ctrl);
        end
        checks++;
        if (cmd_pulse !== '0) begin
            errors++; $display("FAIL reset_cmd got %h expected 0", cmd_pulse);
        end
        checks++;
        if (bus.rd_data !== '0) begin
            errors++; $display("FAIL reset_rd_data got %h expected 0", bus.rd_data);
        end
        reset_n = 1'b1;
        step(1'b0, 1'b1, BASE + 32'h30, '0, '0);
        checks++;
        if (bus.rd_data !== 32'h0) begin
            errors++; $display("FAIL reset_sticky got %h expected 0", bus.rd_data);
        end
        $display("test_reset done");
    endtask

    task automatic test_ctrl_rw();
        step(1'b1, 1'b0, BASE + 32'h08, 32'hDEAD_BEEF, '0);
        checks++;
        if (ctrl[2] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ctrl2_write got %h expected deadbeef", ctrl[2]);
        end
        step(1'b0, 1'b1, BASE + 32'h08, '0, '0);
        checks++;
        if (bus.rd_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ctrl2_read got %h expected deadbeef", bus.rd_data);
        end
        // Random write then read-back of every control word, back to back.
        for (int i = 0; i < 8; i++) begin
            bridge_data_t d = $urandom;
            step(1'b1, 1'b0, BASE + 32'(i * 4) + 32'($urandom_range(0, 3)), d, '0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, BASE + 32'(i * 4), '0, '0);
            checks++;
            if (bus.rd_data !== m_ctrl[i]) begin
                errors++; $display("FAIL ctrl_readback[%0d] got %h expected %h", i, bus.rd_data, m_ctrl[i]);
            end
        end
        // Status, reserved and ID words; writes there must not disturb anything.
        for (int i = 0; i < 4; i++) status[i] = $urandom;
        for (int i = 8; i < 16; i++) begin
            if (i != 12 && i != 13) step(1'b1, 1'b0, BASE + 32'(i * 4), $urandom, '0);
            step(1'b0, 1'b1, BASE + 32'(i * 4), '0, '0);
            checks++;
            if (bus.rd_data !== m_rd) begin
                errors++; $display("FAIL upper_read[%0d] got %h expected %h", i, bus.rd_data, m_rd);
            end
        end
        checks++;
        if (ctrl !== {m_ctrl[7], m_ctrl[6], m_ctrl[5], m_ctrl[4], m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]}) begin
            errors++; $display("FAIL ctrl_after_ro_writes got %h", ctrl);
        end
        $display("test_ctrl_rw done");
    endtask

    task automatic test_sticky();
        step(1'b0, 1'b0, BASE, '0, 32'h5);
        step(1'b0, 1'b1, BASE + 32'h30, '0, '0);
        checks++;
        if (bus.rd_data !== 32'h5) begin
            errors++; $display("FAIL sticky_set got %h expected 5", bus.rd_data);
        end
        step(1'b1, 1'b0, BASE + 32'h30, 32'h1, '0);
        step(1'b0, 1'b1, BASE + 32'h30, '0, '0);
        checks++;
        if (bus.rd_data !== 32'h4) begin
            errors++; $display("FAIL sticky_w1c got %h expected 4", bus.rd_data);
        end
        step(1'b0, 1'b0, BASE, '0, 32'h1);
        step(1'b1, 1'b0, BASE + 32'h30, 32'h1, 32'h1);
        step(1'b0, 1'b1, BASE + 32'h30, '0, '0);
        checks++;
        if (bus.rd_data !== 32'h5) begin
            errors++; $display("FAIL sticky_set_priority got %h expected 5", bus.rd_data);
        end
        // Random events and clears
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 1'b0, BASE + 32'h30, $urandom, $urandom & $urandom);
            step(1'b0, 1'b1, BASE + 32'h30, '0, $urandom & $urandom & $urandom);
            checks++;
            if (bus.rd_data !== m_rd) begin
                errors++; $display("FAIL sticky_random[%0d] got %h expected %h", n, bus.rd_data, m_rd);
            end
        end
        $display("test_sticky done");
    endtask

    task automatic test_cmd();
        step(1'b1, 1'b0, BASE + 32'h34, 32'hA5, '0);
        checks++;
        if (cmd_pulse !== 32'hA5) begin
            errors++; $display("FAIL cmd_pulse got %h expected a5", cmd_pulse);
        end
        idle();
        checks++;
        if (cmd_pulse !== 32'h0) begin
            errors++; $display("FAIL cmd_pulse_end got %h expected 0", cmd_pulse);
        end
        step(1'b0, 1'b1, BASE + 32'h34, '0, '0);
        checks++;
        if (bus.rd_data !== 32'h0) begin
            errors++; $display("FAIL cmd_read got %h expected 0", bus.rd_data);
        end
        $display("test_cmd done");
    endtask

    task automatic test_miss();
        step(1'b1, 1'b0, BASE + 32'h04, 32'h1234, '0);
        step(1'b0, 1'b1, BASE + 32'h04, '0, '0);
        checks++;
        if (bus.rd_data !== 32'h1234) begin
            errors++; $display("FAIL miss_setup got %h expected 1234", bus.rd_data);
        end
        step(1'b0, 1'b1, BASE + 32'h40, '0, '0);
        checks++;
        if (bus.rd_data !== 32'h0) begin
            errors++; $display("FAIL miss_read got %h expected 0", bus.rd_data);
        end
        step(1'b1, 1'b0, BASE + 32'h40, 32'hBAD0_0000, '0);
        step(1'b1, 1'b0, BASE ^ 32'h8000_0000, 32'hBAD0_0001, '0);
        step(1'b1, 1'b0, BASE + 32'h74, 32'hBAD0_0002, '0);
        checks++;
        if (ctrl !== {m_ctrl[7], m_ctrl[6], m_ctrl[5], m_ctrl[4], m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]}) begin
            errors++; $display("FAIL miss_write got %h", ctrl);
        end
        checks++;
        if (cmd_pulse !== 32'h0) begin
            errors++; $display("FAIL miss_cmd got %h expected 0", cmd_pulse);
        end
        $display("test_miss done");
    endtask

    task automatic test_same_cycle();
        step(1'b1, 1'b0, BASE, 32'h1, '0);
        step(1'b1, 1'b1, BASE, 32'h2, '0);
        checks++;
        if (bus.rd_data !== 32'h1) begin
            errors++; $display("FAIL same_cycle_rd got %h expected 1", bus.rd_data);
        end
        checks++;
        if (ctrl[0] !== 32'h2) begin
            errors++; $display("FAIL same_cycle_ctrl got %h expected 2", ctrl[0]);
        end
        $display("test_same_cycle done");
    endtask

    task automatic test_random_mix();
        for (int n = 0; n < 300; n++) begin
            bridge_addr_t a;
            logic w, r;
            if ($urandom_range(0, 3) != 0)
                a = BASE + 32'($urandom_range(0, 63));
            else
                a = BASE ^ (32'($urandom_range(1, 32'h03FF_FFFF)) << 6) ^ 32'($urandom_range(0, 63));
            w = 1'($urandom);
            r = 1'($urandom);
            if (n % 50 == 0) for (int i = 0; i < 4; i++) status[i] = $urandom;
            step(w, r, a, $urandom, $urandom & $urandom & $urandom);
            checks++;
            if (bus.rd_data !== m_rd) begin
                errors++; $display("FAIL mix_rd[%0d] addr %h got %h expected %h", n, a, bus.rd_data, m_rd);
            end
            checks++;
            if (cmd_pulse !== m_cmd) begin
                errors++; $display("FAIL mix_cmd[%0d] got %h expected %h", n, cmd_pulse, m_cmd);
            end
            checks++;
            if (ctrl !== {m_ctrl[7], m_ctrl[6], m_ctrl[5], m_ctrl[4], m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]}) begin
                errors++; $display("FAIL mix_ctrl[%0d] got %h", n, ctrl);
            end
        end
        $display("test_random_mix done");
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, BASE, 32'h2, 32'hF0);
        step(1'b0, 1'b1, BASE, '0, '0);
        step(1'b1, 1'b0, BASE + 32'h34, 32'hFF, '0);
        checks++;
        if (cmd_pulse !== 32'hFF || bus.rd_data !== 32'h2 || ctrl[0] !== 32'h2) begin
            errors++; $display("FAIL mid_reset_setup got cmd %h rd %h ctrl0 %h expected ff 2 2",
                               cmd_pulse, bus.rd_data, ctrl[0]);
        end
        // Assert reset between clock edges and look before any edge arrives.
        reset_n = 1'b0;
        #2;
        checks++;
        if (ctrl !== '0 || cmd_pulse !== '0 || bus.rd_data !== '0) begin
            errors++; $display("FAIL async_reset got ctrl %h cmd %h rd %h expected 0",
                               ctrl, cmd_pulse, bus.rd_data);
        end
        bus.wr = 1'b1; bus.addr = BASE; bus.wr_data = 32'h77; event_in = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.wr = 1'b0; event_in = '0;
        checks++;
        if (ctrl[0] !== '0) begin
            errors++; $display("FAIL reset_hold got %h expected 0", ctrl[0]);
        end
        reset_n = 1'b1;
        model_reset();
        step(1'b0, 1'b1, BASE + 32'h3C, '0, '0);
        checks++;
        if (bus.rd_data !== ID) begin
            errors++; $display("FAIL id_after_reset got %h expected %h", bus.rd_data, ID);
        end
        step(1'b0, 1'b1, BASE + 32'h30, '0, '0);
        checks++;
        if (bus.rd_data !== 32'h0) begin
            errors++; $display("FAIL sticky_after_reset got %h expected 0", bus.rd_data);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_ctrl_rw();
        test_sticky();
        test_cmd();
        test_miss();
        test_same_cycle();
        test_random_mix();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
